// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_reset_sequencer_if                                    |
// | Purpose  : PLL lock/soft-reset inputs and staged reset outputs.      |
// |            lossCount exists only with RESET_SEQ_LOSS_COUNT_EN.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface pll_reset_sequencer_if;
  logic       isLocked;
  logic       softReset;
  logic       periphReset;
  logic       coreReset;
  logic       ready;
  logic [2:0] state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] lossCount;
`endif

`ifdef RESET_SEQ_LOSS_COUNT_EN
  modport master (
    input  isLocked, softReset,
    output periphReset, coreReset, ready, state, lossCount
  );
  modport slave (
    output isLocked, softReset,
    input  periphReset, coreReset, ready, state, lossCount
  );
`else
  modport master (
    input  isLocked, softReset,
    output periphReset, coreReset, ready, state
  );
  modport slave (
    output isLocked, softReset,
    input  periphReset, coreReset, ready, state
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_reset_sequencer                                       |
// | Purpose  : Qualifies PLL lock, holds reset, then releases peripheral |
// |            reset before core reset. Optional RUN lock-loss counter   |
// |            enabled by macro RESET_SEQ_LOSS_COUNT_EN.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int HOLD_CYCLES  = 64,
  parameter int STAGE_CYCLES = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  wire                   clk,
  input  wire                   resetN,
  pll_reset_sequencer_if.master bus
);

  localparam logic [2:0] c_WAIT_LOCK = 3'd0;
  localparam logic [2:0] c_QUALIFY   = 3'd1;
  localparam logic [2:0] c_HOLD      = 3'd2;
  localparam logic [2:0] c_STAGE     = 3'd3;
  localparam logic [2:0] c_RUN       = 3'd4;

  localparam logic [CNT_WIDTH-1:0] c_LOCK_LAST  = CNT_WIDTH'(LOCK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_STAGE_LAST = CNT_WIDTH'(STAGE_CYCLES - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_sync1;
  logic                 r_locked_s;
  logic                 r_periph_reset;
  logic                 r_core_reset;
  logic                 r_ready;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= bus.isLocked;
      r_locked_s <= r_sync1;
    end
  end

  // Priority: lock loss, then softReset, then counter expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (r_locked_s) w_state_nxt = c_QUALIFY;
      end
      c_QUALIFY: begin
        if (!r_locked_s) begin
          w_state_nxt = c_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LOCK_LAST) begin
          w_state_nxt = c_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_HOLD, c_STAGE, c_RUN: begin
        if (!r_locked_s) begin
          w_state_nxt = c_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (bus.softReset) begin
          w_state_nxt = c_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_state == c_HOLD) begin
          if (r_cnt == c_HOLD_LAST) begin
            w_state_nxt = c_STAGE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_state == c_STAGE) begin
          if (r_cnt == c_STAGE_LAST) begin
            w_state_nxt = c_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = c_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as r_state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= c_WAIT_LOCK;
      r_cnt          <= '0;
      r_periph_reset <= 1'b1;
      r_core_reset   <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_periph_reset <= !((w_state_nxt == c_STAGE) || (w_state_nxt == c_RUN));
      r_core_reset   <= (w_state_nxt != c_RUN);
      r_ready        <= (w_state_nxt == c_RUN);
    end
  end

  assign bus.periphReset = r_periph_reset;
  assign bus.coreReset   = r_core_reset;
  assign bus.ready       = r_ready;
  assign bus.state       = r_state;

`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] r_loss_count;
  logic       w_loss_evt;

  // Only lock loss out of RUN counts; softReset never does.
  assign w_loss_evt = (r_state == c_RUN) && !r_locked_s;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_loss_count <= 8'd0;
    end else if (w_loss_evt && (r_loss_count != 8'hFF)) begin
      r_loss_count <= r_loss_count + 8'd1;
    end
  end

  assign bus.lossCount = r_loss_count;
`endif

endmodule
`default_nettype wire
